// File: rtl/mul_sched_pkg.sv
// Shared constants and one-hot helpers for the multiplier-sharing scheduler.
// Helpers work on an 8-bit one-hot space (the largest supported requester count).
package mul_sched_pkg;

    localparam int DW_DEF    = 8;
    localparam int PW_DEF    = 16;
    localparam int MUL_LAT_B = 3;   // mul_para_B pipeline depth, A-in to P-out
    localparam int MAX_REQ   = 8;

    function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] id);
        return 8'(1) << id;
    endfunction

    function automatic logic [2:0] encode(input logic [MAX_REQ-1:0] oh);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) r = 3'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/mul_share_sched_rr_arb.sv
// Round-robin arbiter, combinational grant, highest priority at ptr; 0-cycle latency.
// No backpressure of its own: a masked request vector simply yields no grant.
module rr_arb
    import mul_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id
);

    logic [IW-1:0] ptr;
    logic [N-1:0]  rot;
    logic [N-1:0]  low;
    logic [2:0]    sel;
    logic [IW:0]   sum;

    // Rotate so ptr sits at bit 0, pick the lowest set bit, rotate the index back.
    always_comb begin
        rot    = N'({req, req} >> ptr);
        low    = rot & (~rot + 1'b1);
        sel    = encode(8'(low));
        sum    = {1'b0, ptr} + {1'b0, IW'(sel)};
        if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
        gnt_id = sum[IW-1:0];
        gnt    = (|rot) ? N'(onehot(3'(gnt_id))) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (|gnt) begin
            ptr <= (gnt_id == IW'(N-1)) ? '0 : gnt_id + IW'(1);
        end
    end

endmodule

// File: rtl/mul_share_sched.sv
// Shares one pipelined constant-B multiplier among N_REQ requesters; MUL_LAT+2 cycle latency.
// Backpressure: requesters stall only on lost arbitration or en=0; responses cannot be stalled.
module mul_share_sched
    import mul_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DW      = DW_DEF,
    parameter int PW      = PW_DEF,
    parameter int MUL_LAT = MUL_LAT_B,
    localparam int IDW    = $clog2(N_REQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [N_REQ-1:0]  req_valid,
    output logic [N_REQ-1:0]  req_ready,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [DW-1:0]     mul_a,
    input  logic [PW-1:0]     mul_p,
    output logic [N_REQ-1:0]  rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [PW-1:0]     rsp_data,
    output logic              busy
);

    logic [N_REQ-1:0] gnt;
    logic [IDW-1:0]   gnt_id;
    logic             xfer;
    logic [DW-1:0]    ops [N_REQ];

    logic [MUL_LAT:0] tag_vld;
    logic [IDW-1:0]   tag_id [MUL_LAT+1];

    rr_arb #(.N(N_REQ), .IW(IDW)) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_valid & {N_REQ{en}}),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign req_ready = gnt;
    assign xfer      = |gnt;

    for (genvar i = 0; i < N_REQ; i++) begin : g_ops
        assign ops[i] = req_data[i*DW +: DW];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a <= '0;
        end else if (xfer) begin
            mul_a <= ops[gnt_id];
        end
    end

    // Tag pipe is one stage deeper than the multiplier to cover the mul_a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld <= '0;
            for (int i = 0; i <= MUL_LAT; i++) tag_id[i] <= '0;
        end else begin
            tag_vld   <= {tag_vld[MUL_LAT-1:0], xfer};
            tag_id[0] <= gnt_id;
            for (int i = 1; i <= MUL_LAT; i++) tag_id[i] <= tag_id[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= tag_vld[MUL_LAT] ? N_REQ'(onehot(3'(tag_id[MUL_LAT]))) : '0;
            if (tag_vld[MUL_LAT]) begin
                rsp_id   <= tag_id[MUL_LAT];
                rsp_data <= mul_p;
            end
        end
    end

    assign busy = (|tag_vld) | (|rsp_valid);

endmodule
